// File: rtl/cmos_frame_packer.sv
// ---------------------------------------------------------------------------
// cmos_frame_packer
//
// Packs the 16-bit RGB565 pixel stream from the camera capture path into
// DATA_W-bit words for the DDR write FIFO. Runs entirely in the camera pixel
// clock domain.
//
// Frame handling:
//   - Pixels are discarded until the first vsync rise after reset.
//   - Each later vsync rise flushes any partial word. Unused upper lanes of
//     that word are zero.
//   - Pixel 0 of each word sits in the least-significant 16 bits.
//
// Parameters:
//   DATA_W  output word width. It must be a multiple of 16 and at least 32.
//           Pixels per word: PPW = DATA_W/16.
//
// Optional feature:
//   Define FRAME_SIZE_CHECK_EN to compile in frame geometry checking. When it
//   is left undefined, size_err is tied to 0.
//
// Ports:
//   clk                  camera pixel clock
//   rst_n                asynchronous active-low reset
//   cmos_frame_vsync     frame sync, high during vertical blanking
//   cmos_frame_href      line valid
//   cmos_frame_valid     pixel strobe
//   cmos_frame_data      RGB565 pixel
//   cmos_h_pixel         expected pixels per line (geometry check only)
//   cmos_v_pixel         expected lines per frame (geometry check only)
//   fifo_full            downstream FIFO full
//   fifo_wr_en           one-cycle write strobe
//   fifo_wr_data         packed word
//   frame_start          one-cycle pulse when a new frame begins
//   frame_done           one-cycle pulse when a frame has been flushed
//   frame_cnt            completed-frame counter, wraps at 255
//   overflow             sticky: a word was dropped because the FIFO was full
//   size_err             sticky: frame geometry mismatch
// ---------------------------------------------------------------------------
module cmos_frame_packer #(
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmos_frame_vsync,
  input  logic              cmos_frame_href,
  input  logic              cmos_frame_valid,
  input  logic [15:0]       cmos_frame_data,
  input  logic [12:0]       cmos_h_pixel,
  input  logic [12:0]       cmos_v_pixel,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              overflow,
  output logic              size_err
);

  localparam int PPW   = DATA_W / 16;
  localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [1:0] {WAIT_VS, FRAME, FLUSH} state_t;

  state_t            state_reg;
  logic              vsync_d_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] word_reg;
  // Delays the frame_start pulse after a flush by one cycle, so that it
  // lands in the cycle after frame_done and never in the same cycle.
  logic              start_pending_reg;

  logic              vs_rise;
  logic              pix_ok;
  logic              last_lane;
  logic [DATA_W-1:0] word_merged;

  assign vs_rise   = cmos_frame_vsync & ~vsync_d_reg;
  // A pixel is ignored while vsync is high, whatever the state.
  assign pix_ok    = cmos_frame_valid & ~cmos_frame_vsync;
  assign last_lane = (idx_reg == IDX_W'(PPW - 1));

  // The current word with the incoming pixel placed in lane idx.
  for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
    assign word_merged[16*gi +: 16] = (idx_reg == IDX_W'(gi)) ? cmos_frame_data
                                                               : word_reg[16*gi +: 16];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= WAIT_VS;
      vsync_d_reg       <= 1'b0;
      idx_reg           <= '0;
      word_reg          <= '0;
      start_pending_reg <= 1'b0;
      fifo_wr_en        <= 1'b0;
      fifo_wr_data      <= '0;
      frame_start       <= 1'b0;
      frame_done        <= 1'b0;
      frame_cnt         <= 8'd0;
      overflow          <= 1'b0;
    end else begin
      vsync_d_reg       <= cmos_frame_vsync;
      fifo_wr_en        <= 1'b0;
      frame_start       <= 1'b0;
      frame_done        <= 1'b0;
      start_pending_reg <= 1'b0;

      case (state_reg)
        WAIT_VS: begin
          if (vs_rise) begin
            state_reg   <= FRAME;
            frame_start <= 1'b1;
            idx_reg     <= '0;
            word_reg    <= '0;
          end
        end

        FRAME: begin
          if (start_pending_reg) frame_start <= 1'b1;
          if (vs_rise) begin
            state_reg <= FLUSH;
          end else if (pix_ok) begin
            if (last_lane) begin
              // Clearing the word here leaves the upper lanes of a later
              // partial flush at zero.
              idx_reg  <= '0;
              word_reg <= '0;
              if (fifo_full) begin
                overflow <= 1'b1;
              end else begin
                fifo_wr_en   <= 1'b1;
                fifo_wr_data <= word_merged;
              end
            end else begin
              idx_reg  <= idx_reg + IDX_W'(1);
              word_reg <= word_merged;
            end
          end
        end

        FLUSH: begin
          if (idx_reg != '0) begin
            if (fifo_full) begin
              overflow <= 1'b1;
            end else begin
              fifo_wr_en   <= 1'b1;
              fifo_wr_data <= word_reg;
            end
          end
          frame_done        <= 1'b1;
          frame_cnt         <= frame_cnt + 8'd1;
          idx_reg           <= '0;
          word_reg          <= '0;
          start_pending_reg <= 1'b1;
          state_reg         <= FRAME;
        end

        default: state_reg <= WAIT_VS;
      endcase
    end
  end

`ifdef FRAME_SIZE_CHECK_EN
  logic        href_d_reg;
  logic [12:0] pix_cnt_reg;
  logic [12:0] line_cnt_reg;
  logic        href_fall;

  assign href_fall = ~cmos_frame_href & href_d_reg;

  // Geometry is only judged inside a frame. The counters clear while waiting
  // for the first vsync, and again at each flush, so every frame starts from
  // zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      href_d_reg   <= 1'b0;
      pix_cnt_reg  <= 13'd0;
      line_cnt_reg <= 13'd0;
      size_err     <= 1'b0;
    end else begin
      href_d_reg <= cmos_frame_href;
      if (state_reg == FLUSH) begin
        if (line_cnt_reg != cmos_v_pixel) size_err <= 1'b1;
        pix_cnt_reg  <= 13'd0;
        line_cnt_reg <= 13'd0;
      end else if (state_reg == WAIT_VS) begin
        pix_cnt_reg  <= 13'd0;
        line_cnt_reg <= 13'd0;
      end else begin
        if (href_fall) begin
          if (pix_cnt_reg != cmos_h_pixel) size_err <= 1'b1;
          pix_cnt_reg <= 13'd0;
          if (line_cnt_reg != 13'h1fff) line_cnt_reg <= line_cnt_reg + 13'd1;
        end else if (pix_ok && cmos_frame_href && pix_cnt_reg != 13'h1fff) begin
          pix_cnt_reg <= pix_cnt_reg + 13'd1;
        end
      end
    end
  end
`else
  // Without the geometry check, these inputs have no function.
  logic unused_geom;
  assign unused_geom = ^{cmos_h_pixel, cmos_v_pixel, cmos_frame_href};
  assign size_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_cmos_frame_packer
//
// Directed testbench for cmos_frame_packer with DATA_W=128 (8 pixels per
// word).
//
// A negedge monitor logs every write, frame_start and frame_done, and prints
// one line for each write. Expected words come from build_word.
// ---------------------------------------------------------------------------
module tb_cmos_frame_packer;

  localparam int DATA_W = 128;

`ifdef FRAME_SIZE_CHECK_EN
  localparam logic SZ_EXP = 1'b1;
`else
  localparam logic SZ_EXP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmos_frame_vsync = 1'b0;
  logic              cmos_frame_href = 1'b0;
  logic              cmos_frame_valid = 1'b0;
  logic [15:0]       cmos_frame_data = 16'd0;
  logic [12:0]       cmos_h_pixel = 13'd16;
  logic [12:0]       cmos_v_pixel = 13'd2;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              frame_start;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic              overflow;
  logic              size_err;

  cmos_frame_packer #(.DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmos_frame_vsync (cmos_frame_vsync),
    .cmos_frame_href  (cmos_frame_href),
    .cmos_frame_valid (cmos_frame_valid),
    .cmos_frame_data  (cmos_frame_data),
    .cmos_h_pixel     (cmos_h_pixel),
    .cmos_v_pixel     (cmos_v_pixel),
    .fifo_full        (fifo_full),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .frame_start      (frame_start),
    .frame_done       (frame_done),
    .frame_cnt        (frame_cnt),
    .overflow         (overflow),
    .size_err         (size_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int n_fs = 0;
  int n_fd = 0;
  int fd_cyc = -1;
  logic [DATA_W-1:0] wr_q[$];
  int                wr_cyc[$];

  // Monitor: samples the registered outputs midway between rising edges.
  always @(negedge clk) begin
    cyc_n++;
    if (fifo_wr_en) begin
      wr_q.push_back(fifo_wr_data);
      wr_cyc.push_back(cyc_n);
      $display("WR cyc=%0d data=%h", cyc_n, fifo_wr_data);
    end
    if (frame_start) n_fs++;
    if (frame_done) begin
      n_fd++;
      fd_cyc = cyc_n;
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] build_word(input logic [15:0] base, input int lanes);
    logic [DATA_W-1:0] w;
    w = '0;
    for (int k = 0; k < lanes; k++) w[16*k +: 16] = base + 16'(k);
    return w;
  endfunction

  task automatic cyc(input logic vs, input logic hr, input logic vl,
                     input logic [15:0] d, input logic full);
    cmos_frame_vsync = vs;
    cmos_frame_href  = hr;
    cmos_frame_valid = vl;
    cmos_frame_data  = d;
    fifo_full        = full;
    @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic send_line(input int n, input logic [15:0] base, input int full_at);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, base + 16'(i), (i == full_at));
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);

    // Pixels sent before the first vsync are discarded.
    send_line(10, 16'h0500, -1);
    check("prevs_writes", wr_q.size(), 0);
    check("prevs_frame_start", n_fs, 0);

    // A 16x2 frame bracketed by vsync pulses.
    cmos_h_pixel = 13'd16;
    cmos_v_pixel = 13'd2;
    clear_log();
    vs_pulse();
    send_line(16, 16'h1000, -1);
    send_line(16, 16'h1010, -1);
    check("f1_frame_start", n_fs, 1);
    vs_pulse();
    check("f1_writes", wr_q.size(), 4);
    for (int w = 0; w < 4; w++)
      if (w < wr_q.size()) check($sformatf("f1_word%0d", w), wr_q[w], build_word(16'h1000 + 16'(8*w), 8));
    check("f1_frame_done", n_fd, 1);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_size_err", size_err, 0);

    // A 12-pixel frame ends with a partial word that is flushed.
    cmos_h_pixel = 13'd12;
    cmos_v_pixel = 13'd1;
    clear_log();
    send_line(12, 16'h2000, -1);
    vs_pulse();
    check("f2_writes", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("f2_word0", wr_q[0], build_word(16'h2000, 8));
      check("f2_word1_partial", wr_q[1], build_word(16'h2008, 4));
      check("f2_done_with_flush", fd_cyc, wr_cyc[1]);
    end
    check("f2_frame_cnt", frame_cnt, 2);
    check("f2_size_err", size_err, 0);

    // fifo_full is high when word 2 completes, so that word is dropped.
    cmos_h_pixel = 13'd24;
    cmos_v_pixel = 13'd1;
    clear_log();
    send_line(24, 16'h3000, 15);
    check("ovf_writes", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("ovf_word1", wr_q[0], build_word(16'h3000, 8));
      check("ovf_word3", wr_q[1], build_word(16'h3010, 8));
    end
    check("ovf_flag", overflow, 1);
    vs_pulse();
    check("ovf_no_flush_write", wr_q.size(), 2);
    check("ovf_sticky", overflow, 1);
    check("ovf_frame_cnt", frame_cnt, 3);
    check("ovf_size_err", size_err, 0);

    // A short line: 15 pixels where 16 are expected.
    cmos_h_pixel = 13'd16;
    send_line(15, 16'h4000, -1);
    check("short_line_size_err", size_err, SZ_EXP);
    vs_pulse();
    check("size_err_sticky", size_err, SZ_EXP);

    // Reset asserted mid-word with 3 pixels pending.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 16'h5000 + 16'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", fifo_wr_en, 0);
    check("mid_rst_wr_data", fifo_wr_data, 0);
    check("mid_rst_frame_start", frame_start, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_size_err", size_err, 0);
    clear_log();
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    vs_pulse();
    check("post_rst_no_flush", wr_q.size(), 0);
    check("post_rst_frame_cnt", frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
